// File: rtl/slot_valid_n_if.sv
// Handshake bundle between the fetch/queue logic and the slot-valid tracker.
// master drives fetch/queue status; slave is the tracker.
interface slot_valid_n_if #(
  parameter int unsigned SLOTS = 3,
  parameter int unsigned QW    = 2
);
  logic             branchmiss;
  logic             phit;
  logic [SLOTS-1:0] ip_mask;
  logic [QW-1:0]    qcnt;
  logic [SLOTS-1:0] slot_jc;
  logic [SLOTS-1:0] take_branch;
  logic             debug_on;
  logic [SLOTS-1:0] slotv;
  logic [SLOTS-1:0] slotvd;
  logic [SLOTS-1:0] qslot;
  logic [QW-1:0]    nq;
  logic             nextb;
  logic             busy;

  modport master (
    output branchmiss, phit, ip_mask, qcnt, slot_jc, take_branch, debug_on,
    input  slotv, slotvd, qslot, nq, nextb, busy
  );

  modport slave (
    input  branchmiss, phit, ip_mask, qcnt, slot_jc, take_branch, debug_on,
    output slotv, slotvd, qslot, nq, nextb, busy
  );
endinterface

// File: rtl/slot_valid_n.sv
// Slot-valid tracker: holds the pending-slot mask of the current fetch bundle and
// picks up to WAYS oldest pending slots per cycle for the instruction queue.
module slot_valid_n #(
  parameter int unsigned SLOTS     = 3,
  parameter int unsigned WAYS      = 3,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned QW        = $clog2(WAYS + 1)
) (
  input logic           clk,
  input logic           rst,
  slot_valid_n_if.slave bus
);

  localparam logic [1:0] StEmpty  = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StFlush  = 2'd2;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYC);

  logic [1:0]       state_q, state_d;
  logic [SLOTS-1:0] slotv_q, slotv_d;
  logic [SLOTS-1:0] slotvd_q, slotvd_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [SLOTS-1:0] qslot;
  logic             trunc;
  logic [QW-1:0]    nq;
  logic             nextb;

  // Pick the oldest k pending slots; stop after the first taken jump/call/branch.
  always_comb begin : p_select
    int unsigned lim;
    int unsigned taken;
    qslot = '0;
    trunc = 1'b0;
    taken = 0;
    lim   = 32'(bus.qcnt);
    if (lim > WAYS) lim = WAYS;
    if (bus.debug_on && lim > 1) lim = 1;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (slotv_q[i] && taken < lim && !trunc) begin
        qslot[i] = 1'b1;
        taken++;
        if (bus.slot_jc[i] || bus.take_branch[i]) trunc = 1'b1;
      end
    end
    if (state_q != StActive || bus.branchmiss) begin
      qslot = '0;
      trunc = 1'b0;
    end
  end

  // Issue count is the popcount of the selected mask.
  always_comb begin
    nq = '0;
    for (int unsigned i = 0; i < SLOTS; i++) nq = nq + QW'(qslot[i]);
  end

  // State machine and pending-mask update; branchmiss wins over everything but reset.
  always_comb begin
    state_d  = state_q;
    slotv_d  = slotv_q;
    slotvd_d = slotvd_q;
    fcnt_d   = fcnt_q;
    nextb    = 1'b0;
    if (bus.branchmiss) begin
      slotv_d = '0;
      if (FLUSH_CYC > 0) begin
        state_d = StFlush;
        fcnt_d  = FlushLoad;
      end else begin
        state_d = StEmpty;
        fcnt_d  = '0;
      end
    end else begin
      case (state_q)
        StEmpty: begin
          if (bus.phit) begin
            if (bus.ip_mask != '0) begin
              slotv_d  = bus.ip_mask;
              slotvd_d = bus.ip_mask;
              state_d  = StActive;
            end else begin
              // Empty bundle: nothing to hold, ask for the next one right away.
              nextb = 1'b1;
            end
          end
        end
        StActive: begin
          slotv_d = trunc ? '0 : (slotv_q & ~qslot);
          if (slotv_d == '0) begin
            nextb   = 1'b1;
            state_d = StEmpty;
          end
        end
        StFlush: begin
          slotv_d = '0;
          fcnt_d  = (fcnt_q != 4'd0) ? fcnt_q - 4'd1 : 4'd0;
          if (fcnt_q <= 4'd1) state_d = StEmpty;
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEmpty;
      slotv_q  <= '0;
      slotvd_q <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      slotv_q  <= slotv_d;
      slotvd_q <= slotvd_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign bus.slotv  = slotv_q;
  assign bus.slotvd = slotvd_q;
  assign bus.qslot  = qslot;
  assign bus.nq     = nq;
  assign bus.nextb  = nextb;
  assign bus.busy   = (state_q != StEmpty);

endmodule

// File: tb/tb_slot_valid_n.sv
// Directed bench for slot_valid_n: one 3-slot/3-way instance with a 2-cycle flush,
// one 4-slot/2-way instance.
module tb_slot_valid_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  slot_valid_n_if #(.SLOTS(3), .QW(2)) a_if ();
  slot_valid_n_if #(.SLOTS(4), .QW(2)) b_if ();

  slot_valid_n #(.SLOTS(3), .WAYS(3), .FLUSH_CYC(2), .QW(2)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  slot_valid_n #(.SLOTS(4), .WAYS(2), .FLUSH_CYC(1), .QW(2)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; registered outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic ph, input logic [2:0] ip, input logic [1:0] qc);
    a_if.phit    = ph;
    a_if.ip_mask = ip;
    a_if.qcnt    = qc;
  endtask

  initial begin
    a_if.branchmiss = 1'b0; a_if.phit = 1'b0; a_if.ip_mask = '0; a_if.qcnt = '0;
    a_if.slot_jc = '0; a_if.take_branch = '0; a_if.debug_on = 1'b0;
    b_if.branchmiss = 1'b0; b_if.phit = 1'b0; b_if.ip_mask = '0; b_if.qcnt = '0;
    b_if.slot_jc = '0; b_if.take_branch = '0; b_if.debug_on = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_slotv", a_if.slotv, 0);
    chk("rst_slotvd", a_if.slotvd, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_qslot", a_if.qslot, 0);
    chk("rst_nextb", a_if.nextb, 0);

    // Full bundle, full width
    drive_a(1'b1, 3'b111, 2'd3); #1;
    chk("load_no_qslot", a_if.qslot, 0);
    chk("load_no_nextb", a_if.nextb, 0);
    tick();
    drive_a(1'b0, 3'b000, 2'd3);
    chk("full_slotv", a_if.slotv, 3'b111);
    chk("full_slotvd", a_if.slotvd, 3'b111);
    chk("full_busy", a_if.busy, 1);
    #1;
    chk("full_qslot", a_if.qslot, 3'b111);
    chk("full_nq", a_if.nq, 3);
    chk("full_nextb", a_if.nextb, 1);
    tick();
    chk("full_done_slotv", a_if.slotv, 0);
    chk("full_done_busy", a_if.busy, 0);

    // Partial issue, two per cycle
    drive_a(1'b1, 3'b111, 2'd2);
    tick();
    a_if.phit = 1'b0; #1;
    chk("part1_qslot", a_if.qslot, 3'b011);
    chk("part1_nq", a_if.nq, 2);
    chk("part1_nextb", a_if.nextb, 0);
    tick();
    chk("part2_slotv", a_if.slotv, 3'b100);
    #1;
    chk("part2_qslot", a_if.qslot, 3'b100);
    chk("part2_nq", a_if.nq, 1);
    chk("part2_nextb", a_if.nextb, 1);
    tick();
    chk("part_done_busy", a_if.busy, 0);

    // Predicted-taken branch in slot 1 drops slot 2
    drive_a(1'b1, 3'b111, 2'd3);
    a_if.take_branch = 3'b010;
    tick();
    a_if.phit = 1'b0; #1;
    chk("br_qslot", a_if.qslot, 3'b011);
    chk("br_nq", a_if.nq, 2);
    chk("br_nextb", a_if.nextb, 1);
    tick();
    chk("br_slotv", a_if.slotv, 0);
    chk("br_busy", a_if.busy, 0);

    // Jump/call in slot 0
    a_if.take_branch = '0;
    a_if.slot_jc = 3'b001;
    drive_a(1'b1, 3'b111, 2'd3);
    tick();
    a_if.phit = 1'b0; #1;
    chk("jc_qslot", a_if.qslot, 3'b001);
    chk("jc_nq", a_if.nq, 1);
    chk("jc_nextb", a_if.nextb, 1);
    tick();
    chk("jc_slotv", a_if.slotv, 0);
    a_if.slot_jc = '0;

    // Entry mask with single-step
    a_if.debug_on = 1'b1;
    drive_a(1'b1, 3'b110, 2'd3);
    tick();
    a_if.phit = 1'b0;
    chk("dbg_slotvd", a_if.slotvd, 3'b110);
    #1;
    chk("dbg1_qslot", a_if.qslot, 3'b010);
    chk("dbg1_nextb", a_if.nextb, 0);
    tick();
    chk("dbg2_slotv", a_if.slotv, 3'b100);
    #1;
    chk("dbg2_qslot", a_if.qslot, 3'b100);
    chk("dbg2_nextb", a_if.nextb, 1);
    tick();
    a_if.debug_on = 1'b0;

    // Empty bundle: advance immediately, no load
    drive_a(1'b1, 3'b000, 2'd3); #1;
    chk("empty_nextb", a_if.nextb, 1);
    tick();
    a_if.phit = 1'b0;
    chk("empty_busy", a_if.busy, 0);
    chk("empty_slotvd", a_if.slotvd, 3'b110);

    // Flush mid-bundle (FLUSH_CYC=2)
    drive_a(1'b1, 3'b111, 2'd1);
    tick();
    a_if.phit = 1'b0;
    a_if.branchmiss = 1'b1; #1;   // cycle t
    chk("bm_qslot", a_if.qslot, 0);
    chk("bm_nq", a_if.nq, 0);
    chk("bm_nextb", a_if.nextb, 0);
    tick();                       // t+1
    a_if.branchmiss = 1'b0;
    chk("fl1_slotv", a_if.slotv, 0);
    chk("fl1_busy", a_if.busy, 1);
    drive_a(1'b1, 3'b011, 2'd1); #1;
    chk("fl1_qslot", a_if.qslot, 0);
    chk("fl1_nextb", a_if.nextb, 0);
    tick();                       // t+2
    chk("fl2_busy", a_if.busy, 1);
    chk("fl2_slotv", a_if.slotv, 0);
    tick();                       // t+3, load accepted here
    chk("fl3_busy", a_if.busy, 0);
    chk("fl3_slotv", a_if.slotv, 0);
    tick();                       // t+4
    a_if.phit = 1'b0;
    chk("fl4_slotv", a_if.slotv, 3'b011);
    chk("fl4_slotvd", a_if.slotvd, 3'b011);
    #1;
    chk("fl4_qslot", a_if.qslot, 3'b001);
    tick();
    #1;
    chk("fl5_qslot", a_if.qslot, 3'b010);
    chk("fl5_nextb", a_if.nextb, 1);
    tick();

    // qcnt=0 holds, then back-to-back branchmiss extends flush
    drive_a(1'b1, 3'b111, 2'd0);
    tick();
    a_if.phit = 1'b0; #1;
    chk("q0_qslot", a_if.qslot, 0);
    chk("q0_nextb", a_if.nextb, 0);
    a_if.branchmiss = 1'b1;
    tick();                       // t+1
    chk("q0_held_bm_slotv", a_if.slotv, 0);
    tick();                       // t+2
    a_if.branchmiss = 1'b0;
    chk("ext2_busy", a_if.busy, 1);
    tick();                       // t+3
    chk("ext3_busy", a_if.busy, 1);
    tick();                       // t+4
    chk("ext4_busy", a_if.busy, 0);

    // 4 slots, 2 ways: qcnt clamps to WAYS
    b_if.phit = 1'b1; b_if.ip_mask = 4'b1011; b_if.qcnt = 2'd3;
    tick();
    b_if.phit = 1'b0;
    chk("b_slotv", b_if.slotv, 4'b1011);
    #1;
    chk("b1_qslot", b_if.qslot, 4'b0011);
    chk("b1_nq", b_if.nq, 2);
    chk("b1_nextb", b_if.nextb, 0);
    tick();
    chk("b2_slotv", b_if.slotv, 4'b1000);
    #1;
    chk("b2_qslot", b_if.qslot, 4'b1000);
    chk("b2_nq", b_if.nq, 1);
    chk("b2_nextb", b_if.nextb, 1);
    tick();
    chk("b_done_busy", b_if.busy, 0);

    // rst together with branchmiss gives reset values
    b_if.phit = 1'b1; b_if.ip_mask = 4'b1111; b_if.qcnt = 2'd0;
    tick();
    b_if.phit = 1'b0;
    chk("b_load_busy", b_if.busy, 1);
    rst = 1'b1;
    b_if.branchmiss = 1'b1;
    tick();
    rst = 1'b0;
    b_if.branchmiss = 1'b0;
    chk("rstbm_slotv", b_if.slotv, 0);
    chk("rstbm_slotvd", b_if.slotvd, 0);
    chk("rstbm_busy", b_if.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slot_valid_n.md
# slot_valid_n

Parametrised slot-valid tracker for the fetch/queue boundary. It holds the pending-slot mask of the current instruction bundle (SLOTS wide) and selects, each cycle, up to WAYS oldest pending slots for the instruction queue. It truncates selection at the first jump/call or predicted-taken branch, and requests the next bundle once all slots are consumed. It adds an explicit EMPTY/ACTIVE/FLUSH state machine with a programmable post-miss flush delay.

## Interface
- SLOTS, 3, instruction slots per bundle; slot 0 is oldest.
- WAYS, 3, maximum slots queued per cycle (1..SLOTS).
- FLUSH_CYC, 1, cycles fetch input is ignored after branchmiss (0..15).
- QW, $clog2(WAYS+1), width of count fields.

Ports:
- clk  in  1  clock; one clock domain; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- branchmiss  in  1  pipeline flush.
- phit  in  1  fetch bundle present and valid this cycle.
- ip_mask  in  SLOTS  slots of the fetched bundle that are live (entry-point mask).
- qcnt  in  QW  queue slots free this cycle.
- slot_jc  in  SLOTS  slot holds an unconditional jump/call.
- take_branch  in  SLOTS  slot holds a predicted-taken branch.
- debug_on  in  1  single-step mode; limits issue to one slot per cycle.
- slotv  out  SLOTS  registered pending-slot mask.
- slotvd  out  SLOTS  registered ip_mask of the bundle as loaded.
- qslot  out  SLOTS  combinational mask of slots queued this cycle.
- nq  out  QW  combinational popcount of qslot.
- nextb  out  1  combinational; the current bundle is finished, advance fetch.
- busy  out  1  registered; state != EMPTY.

## Operation
- States: EMPTY, ACTIVE, FLUSH. Reset: state EMPTY, slotv 0, slotvd 0, flush counter 0, busy 0. With no active bundle, qslot, nq and nextb are 0.
- EMPTY:
  - phit=1 and ip_mask!=0: slotv<=ip_mask, slotvd<=ip_mask, go ACTIVE.
  - phit=1 and ip_mask=0: nextb=1, stay EMPTY.
  - phit=0: idle.
- ACTIVE:
  - Issue limit k = min(qcnt, WAYS), forced to min(qcnt,1) when debug_on=1.
  - Candidate mask = the first k set bits of slotv, lowest index first.
  - Let b be the lowest candidate slot with slot_jc|take_branch set. If b exists, qslot = candidates with index <= b, and slotv<=0.
  - Otherwise qslot = candidates and slotv<=slotv & ~qslot.
  - nextb=1 when the next slotv is 0. In that case the next state is EMPTY; otherwise the state stays ACTIVE.
  - qcnt=0 gives qslot=0 and holds slotv.
  - phit is ignored in ACTIVE; a new bundle is loaded only from EMPTY, which gives one bubble between bundles.
- FLUSH:
  - The counter decrements each cycle. When it reaches 0 the state goes to EMPTY.
  - phit, qcnt and all outputs except slotv=0 and busy=1 are ignored or forced to 0.
- branchmiss has top priority in every state:
  - slotv<=0, and qslot=0, nq=0, nextb=0 in that cycle.
  - If FLUSH_CYC>0: go FLUSH with counter<=FLUSH_CYC. A branchmiss during FLUSH reloads the counter.
  - If FLUSH_CYC=0: go EMPTY.
- rst overrides branchmiss.
- slot_jc and take_branch are only examined for candidate slots. Bits for slots that are not pending are don't-care.

## Timing
- slotv and slotvd are valid the cycle after the phit load. The first issue happens in the cycle after load.
- qslot, nq and nextb are combinational from the registered slotv and the current qcnt, slot_jc, take_branch and debug_on. There is no path from phit or ip_mask to qslot.
- With full issue width, a bundle with m live slots takes ceil(m/k) ACTIVE cycles.
- After branchmiss in cycle t, the earliest load is cycle t+FLUSH_CYC+1, and the earliest qslot!=0 is cycle t+FLUSH_CYC+2.
- nq always equals popcount(qslot) and never exceeds WAYS.

## Test plan
- Reset then bundle: rst 2 cycles, phit with ip_mask=111 and qcnt=3 → slotv=111 and slotvd=111 next cycle. The following cycle gives qslot=111, nq=3, nextb=1; then slotv=000 and state EMPTY.
- Partial issue: ip_mask=111 with qcnt=2 then 2 → cycle 1: qslot=011, slotv becomes 100. Cycle 2: qslot=100, nq=1, nextb=1.
- Branch truncation: ip_mask=111, qcnt=3, take_branch=010 → qslot=011, nq=2, nextb=1, slotv becomes 000 (slot 2 dropped). Repeat with slot_jc=001 → qslot=001.
- Entry mask and debug: ip_mask=110, qcnt=3, debug_on=1 → successive qslot=010 then 100, with nextb only on the second. ip_mask=000 with phit → nextb=1 in the same cycle and no load.
- Flush: FLUSH_CYC=2, branchmiss mid-bundle at cycle t.
  - Required: slotv=0 at t+1 and busy=1 through t+2.
  - phit at t+1..t+2 is ignored; a load at t+3 is accepted.
  - A second branchmiss at t+1 extends FLUSH to t+3.
- Parameter sweep SLOTS=4, WAYS=2: ip_mask=1011, qcnt=3 → qslot=0011 then 1000. Also check branchmiss and rst asserted together → reset values.
